rgb_pwm_blinker: RTL and testbench

//  Parametrised N-channel LED driver that replaces free-running counter blink.
//  Per channel: OFF, ON (PWM dimmed), BLINK or BREATHE (triangle ramp), with brightness level.

---
 rtl/rgb_pwm_blinker.sv | 196 +++++++++++++++++++
 tb/tb_rgb_pwm_blinker.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_blinker.sv
// N-channel active-low LED driver: OFF / ON / BLINK / BREATHE with PWM dimming.
// Config writes are held in a shadow and committed on the last PWM count.
module rgb_pwm_blinker #(
  parameter int CHANNELS    = 3,
  parameter int PWM_W       = 8,
  parameter int TICK_DIV    = 46875,
  parameter int BLINK_TICKS = 64,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_W-1:0]    cfg_level,
  output logic [CHANNELS-1:0] rgb
);

  localparam int PRE_W =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BL_W =
    (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX =
    PRE_W'(TICK_DIV - 1);
  localparam logic [BL_W-1:0] BL_MAX =
    BL_W'(BLINK_TICKS - 1);
  localparam logic [PWM_W-1:0] PWM_MAX = '1;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef enum logic {
    S_IDLE,
    S_PEND
  } state_e;

  logic [PWM_W-1:0] r_pwm;
  logic [PRE_W-1:0] r_pre;
  logic [BL_W-1:0]  r_bcnt;
  logic             r_bphase;

  logic w_tick;
  logic w_pwm_end;

  assign w_tick    = (r_pre == PRE_MAX);
  assign w_pwm_end = (r_pwm == PWM_MAX);

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_pwm    <= '0;
      r_pre    <= '0;
      r_bcnt   <= '0;
      r_bphase <= 1'b0;
    end else begin
      r_pwm <= r_pwm + 1'b1;
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) begin
        if (r_bcnt == BL_MAX) begin
          r_bcnt   <= '0;
          r_bphase <= ~r_bphase;
        end else begin
          r_bcnt <= r_bcnt + 1'b1;
        end
      end
    end
  end

  state_e r_state;
  state_e w_state_nxt;
  logic   w_accept;
  logic   w_commit;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pending is only tested from S_PEND, so a write taken
  // on the last count waits a full period before commit.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (cfg_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_PEND;
        end
      end
      S_PEND: begin
        if (w_pwm_end) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  assign cfg_ready = (r_state == S_IDLE);

  logic [CH_W-1:0]  r_pch;
  mode_e            r_pmode;
  logic [PWM_W-1:0] r_plvl;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_pch   <= '0;
      r_pmode <= MODE_OFF;
      r_plvl  <= '0;
    end else if (w_accept) begin
      r_pch   <= cfg_ch;
      r_pmode <= mode_e'(cfg_mode);
      r_plvl  <= cfg_level;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    mode_e            r_mode;
    logic [PWM_W-1:0] r_lvl;
    logic [PWM_W-1:0] r_brt;
    logic             r_dn;
    logic             r_on;

    logic             w_hit;
    logic [PWM_W-1:0] w_brt_nxt;
    logic             w_dn_nxt;
    logic [PWM_W-1:0] w_duty;

    // Out-of-range channel numbers match no g and are dropped.
    assign w_hit = w_commit && (r_pch == CH_W'(g));

    always_comb begin
      w_brt_nxt = r_brt;
      w_dn_nxt  = r_dn;
      if (!r_dn) begin
        if (r_brt == r_lvl) begin
          w_dn_nxt  = 1'b1;
          w_brt_nxt = (r_lvl == '0) ? '0 : r_lvl - 1'b1;
        end else begin
          w_brt_nxt = r_brt + 1'b1;
        end
      end else begin
        if (r_brt == '0) begin
          w_dn_nxt  = 1'b0;
          w_brt_nxt = (r_lvl == '0) ? '0 : PWM_W'(1);
        end else begin
          w_brt_nxt = r_brt - 1'b1;
        end
      end
    end

    always_comb begin
      w_duty = '0;
      unique case (1'b1)
        (r_mode == MODE_ON):      w_duty = r_lvl;
        (r_mode == MODE_BLINK):   w_duty = r_bphase ? r_lvl : '0;
        (r_mode == MODE_BREATHE): w_duty = r_brt;
        default:                  w_duty = '0;
      endcase
    end

    always_ff @(posedge clk_in) begin
      if (!rst_n) begin
        r_mode <= MODE_OFF;
        r_lvl  <= '0;
        r_brt  <= '0;
        r_dn   <= 1'b0;
        r_on   <= 1'b0;
      end else begin
        if (w_hit) begin
          r_mode <= r_pmode;
          r_lvl  <= r_plvl;
          r_brt  <= '0;
          r_dn   <= 1'b0;
        end else if (w_tick) begin
          r_brt <= w_brt_nxt;
          r_dn  <= w_dn_nxt;
        end
        r_on <= (r_pwm < w_duty);
      end
    end

    assign rgb[g] = ~r_on;
  end

endmodule

// File: tb/tb_rgb_pwm_blinker.sv
// Directed bench for rgb_pwm_blinker with a 16-cycle PWM period,
// 4-cycle effect tick and 2-tick blink half-period.
module tb_rgb_pwm_blinker;

  localparam int CHANNELS    = 3;
  localparam int PWM_W       = 4;
  localparam int TICK_DIV    = 4;
  localparam int BLINK_TICKS = 2;

  logic             clk_in    = 1'b0;
  logic             rst_n     = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_ch    = '0;
  logic [1:0]       cfg_mode  = '0;
  logic [PWM_W-1:0] cfg_level = '0;
  logic [2:0]       rgb;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk_in = ~clk_in;

  rgb_pwm_blinker #(
    .CHANNELS   (CHANNELS),
    .PWM_W      (PWM_W),
    .TICK_DIV   (TICK_DIV),
    .BLINK_TICKS(BLINK_TICKS)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_level(cfg_level),
    .rgb      (rgb)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp_v);
    end
  endtask

  task automatic wait_phase(input int p);
    while (cyc % 16 != p) tick();
  endtask

  task automatic write_cfg(input int p, input int ch,
                           input int mode, input int lvl,
                           input int exp_lat,
                           input string tag);
    int n;
    wait_phase(p);
    chk({tag, "_rdy"}, 32'(cfg_ready), 1);
    cfg_ch    = 2'(ch);
    cfg_mode  = 2'(mode);
    cfg_level = PWM_W'(lvl);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    n = 0;
    while (!cfg_ready && n < 40) begin
      n++;
      tick();
    end
    chk({tag, "_lat"}, n, exp_lat);
  endtask

  task automatic window(input string tag, input int e0,
                        input int e1, input int e2);
    int l0, l1, l2;
    l0 = 0; l1 = 0; l2 = 0;
    repeat (16) begin
      tick();
      l0 += int'(!rgb[0]);
      l1 += int'(!rgb[1]);
      l2 += int'(!rgb[2]);
    end
    chk({tag, "_ch0"}, l0, e0);
    chk({tag, "_ch1"}, l1, e1);
    chk({tag, "_ch2"}, l2, e2);
  endtask

  task automatic breathe(input string tag);
    int seq [6];
    int cs, k, lows, bad;
    logic e;
    seq  = '{0, 1, 2, 3, 2, 1};
    cs   = cyc;
    lows = 0;
    bad  = 0;
    repeat (48) begin
      tick();
      k = cyc - 1 - cs;
      e = !(((cyc - 1) % 16) < seq[(k / 4) % 6]);
      if (rgb[0] !== e) bad++;
      lows += int'(!rgb[0]);
    end
    chk({tag, "_badcyc"}, bad, 0);
    chk({tag, "_lows"}, lows, 4);
  endtask

  initial begin
    int n, l, bad;

    for (int i = 0; i < 5; i++) begin
      @(posedge clk_in);
      #1;
      chk("rst_rgb", 32'(rgb), 7);
    end
    rst_n = 1'b1;
    cyc   = 0;
    chk("rel_rdy", 32'(cfg_ready), 1);
    chk("rel_rgb", 32'(rgb), 7);

    write_cfg(5, 0, 1, 4, 10, "t2");
    window("t2", 4, 0, 0);

    write_cfg(5, 1, 1, 15, 10, "t3a");
    window("t3a", 4, 15, 0);
    write_cfg(5, 1, 1, 0, 10, "t3b");
    window("t3b", 4, 0, 0);

    write_cfg(5, 2, 2, 15, 10, "t4");
    window("t4", 4, 0, 7);

    write_cfg(5, 0, 3, 3, 10, "t5a");
    breathe("t5a");
    write_cfg(5, 0, 3, 3, 10, "t5b");
    breathe("t5b");

    write_cfg(15, 0, 0, 0, 16, "t5c");
    window("t5c", 0, 0, 7);

    wait_phase(5);
    chk("t6a_rdy", 32'(cfg_ready), 1);
    cfg_ch    = 2'd1;
    cfg_mode  = 2'd1;
    cfg_level = 4'd8;
    cfg_valid = 1'b1;
    tick();
    cfg_level = 4'd2;
    n = 0;
    while (!cfg_ready && n < 40) begin
      n++;
      tick();
    end
    chk("t6a_hold", n, 10);
    tick();
    cfg_valid = 1'b0;
    n = 0;
    l = 0;
    while (!cfg_ready && n < 40) begin
      l += int'(!rgb[1]);
      n++;
      tick();
    end
    chk("t6a_lat2", n, 15);
    chk("t6a_w1", l, 8);
    window("t6a", 0, 2, 7);

    write_cfg(5, 3, 1, 15, 10, "t6b");
    window("t6b", 0, 2, 7);

    wait_phase(5);
    cfg_ch    = 2'd1;
    cfg_mode  = 2'd1;
    cfg_level = 4'd15;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("t6c_pend", 32'(cfg_ready), 0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("t6c_rst_rgb", 32'(rgb), 7);
    chk("t6c_rst_rdy", 32'(cfg_ready), 1);
    tick();
    rst_n = 1'b1;
    cyc   = 0;
    bad   = 0;
    repeat (40) begin
      tick();
      if (rgb !== 3'b111 || cfg_ready !== 1'b1) bad++;
    end
    chk("t6c_lost", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
